// File: rtl/fetch_ctrl_if.sv
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Instruction-memory read bus and decode-side valid/ready bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_ctrl_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc
   );
endinterface

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Brief    : PC sequencer with prefetch queue feeding decode over valid/ready.
//            Optional bounds checking enabled by macro FETCH_BOUNDS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 400,
   parameter int unsigned QDEPTH    = 2
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        fetch_en_i,
   input  wire logic        redirect_valid_i,
   input  wire logic [31:0] redirect_pc_i,
   fetch_ctrl_if.master     bus,
   output logic             fault_o
);

   localparam int unsigned   c_pw        = $clog2(QDEPTH);
   localparam int unsigned   c_cw        = c_pw + 1;
   localparam logic [c_cw-1:0] c_full    = c_cw'(QDEPTH);
   localparam logic [31:0]   c_last_word = 32'(MEM_BYTES - 4);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t            state_q;
   logic [31:0]       pc_q;
   logic [c_cw-1:0]   count_q;
   logic [c_pw-1:0]   rd_q;
   logic [c_pw-1:0]   wr_q;
   logic              fault_q;
   logic [63:0]       entry_q [QDEPTH];

   logic w_pop;
   logic w_redirect;
   logic w_try;
   logic w_oor;
   logic w_redir_bad;
   logic w_push;
   logic w_fetch_bad;

`ifdef FETCH_BOUNDS_CHECK_EN
   assign w_oor       = (pc_q[1:0] != 2'b00) || (pc_q > c_last_word);
   assign w_redir_bad = (redirect_pc_i[1:0] != 2'b00);
`else
   assign w_oor       = 1'b0;
   assign w_redir_bad = 1'b0;
`endif

   assign w_pop       = bus.out_valid & bus.out_ready;
   assign w_redirect  = redirect_valid_i & (state_q != S_FAULT);
   // A fetch is attempted only when the queue can take the word this cycle.
   assign w_try       = (state_q == S_FETCH) & fetch_en_i & ~redirect_valid_i
                        & ((count_q < c_full) | w_pop);
   assign w_push      = w_try & ~w_oor;
   assign w_fetch_bad = w_try & w_oor;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         count_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         fault_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE) begin
            state_q <= S_FETCH;
         end

         if (w_redirect) begin
            // Flush wins over any same-cycle pop; the popped head is discarded.
            pc_q    <= redirect_pc_i;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            if (w_redir_bad) begin
               fault_q <= 1'b1;
               state_q <= S_FAULT;
            end
         end else begin
            if (w_push) begin
               entry_q[wr_q] <= {bus.imem_rdata, pc_q};
               wr_q          <= wr_q + c_pw'(1);
               pc_q          <= pc_q + 32'd4;
            end
            if (w_pop) begin
               rd_q <= rd_q + c_pw'(1);
            end
            case ({w_push, w_pop})
               2'b10:   count_q <= count_q + c_cw'(1);
               2'b01:   count_q <= count_q - c_cw'(1);
               default: count_q <= count_q;
            endcase
            if (w_fetch_bad) begin
               fault_q <= 1'b1;
               state_q <= S_FAULT;
            end
         end
      end
   end

   assign bus.imem_addr = pc_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_instr = entry_q[rd_q][63:32];
   assign bus.out_pc    = entry_q[rd_q][31:0];
   assign fault_o       = fault_q;

endmodule

`default_nettype wire
